// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding, step count and a small sign helper.
package muldiv_ctrl_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: a radix-2 shift-add multiply step or a
// restoring-division step on the {acc_hi, acc_lo} pair.
//   multiply: acc_lo holds the remaining multiplier bits, opnd the multiplicand
//   divide:   acc_lo holds the remaining dividend / growing quotient,
//             acc_hi the partial remainder, opnd the divisor
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_s;
    logic             ge_s;
    logic [WIDTH-1:0] sub_s;

    // Compute both step flavours and select the one for the current op.
    always_comb begin
        sum_s  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_s  = {acc_hi, acc_lo[WIDTH-1]};
        ge_s   = (rem_s >= {1'b0, opnd});
        // Remainder after a successful subtract is below the divisor, so the
        // low WIDTH bits of the modular difference are exact.
        sub_s  = rem_s[WIDTH-1:0] - opnd;
        nxt_hi = acc_hi;
        nxt_lo = acc_lo;
        if (is_div) begin
            if (ge_s) begin
                nxt_hi = sub_s;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = rem_s[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum_s[WIDTH:1];
            nxt_lo = {sum_s[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style MULT/MULTU/DIV/DIVU unit: accepts one E-stage
// operation when idle, runs 32 single-bit steps, corrects signs, then writes
// HI/LO. Divide by zero short-circuits straight to the fix-up cycle.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_e,
    input  logic [1:0]       op_e,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush_e,
    input  logic             mfhi_d,
    input  logic             mflo_d,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_zero
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [4:0]       cnt_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH-1:0] opnd_r;
    logic             is_div_r;
    logic             neg_res_r;
    logic             neg_rem_r;
    logic             dz_r;

    logic             accept_s;
    logic             dz_s;
    logic             is_signed_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] ld_hi_s;
    logic [WIDTH-1:0] ld_lo_s;
    logic [WIDTH-1:0] ld_opnd_s;
    logic             ld_neg_res_s;
    logic             ld_neg_rem_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;
    logic [2*WIDTH-1:0] prod_neg_s;

    assign accept_s  = start_e & ~flush_e & (state_r == ST_IDLE);
    assign dz_s      = op_e[1] & (src_b == {WIDTH{1'b0}});
    assign busy      = (state_r != ST_IDLE);
    assign stall_req = busy & (start_e | mfhi_d | mflo_d);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_r),
        .acc_hi (acc_hi_r),
        .acc_lo (acc_lo_r),
        .opnd   (opnd_r),
        .nxt_hi (step_hi_s),
        .nxt_lo (step_lo_s)
    );

    // Operand conditioning at accept: magnitudes and result signs for signed ops.
    always_comb begin
        is_signed_s  = (op_e == OP_MULT) || (op_e == OP_DIV);
        a_mag_s      = is_signed_s ? abs32(src_a) : src_a;
        b_mag_s      = is_signed_s ? abs32(src_b) : src_b;
        ld_neg_res_s = is_signed_s & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        ld_neg_rem_s = is_signed_s & src_a[WIDTH-1];
        ld_hi_s      = {WIDTH{1'b0}};
        ld_lo_s      = {WIDTH{1'b0}};
        ld_opnd_s    = {WIDTH{1'b0}};
        if (dz_s) begin
            // Trap-free divide by zero: fixed result, no sign correction.
            ld_hi_s      = src_a;
            ld_lo_s      = {WIDTH{1'b1}};
            ld_neg_res_s = 1'b0;
            ld_neg_rem_s = 1'b0;
        end else if (op_e[1]) begin
            ld_lo_s   = a_mag_s;
            ld_opnd_s = b_mag_s;
        end else begin
            ld_lo_s   = b_mag_s;
            ld_opnd_s = a_mag_s;
        end
    end

    assign prod_neg_s = -{acc_hi_r, acc_lo_r};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = dz_s ? ST_FIX : ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == 5'(STEPS - 1)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath, step counter and architectural HI/LO/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= 5'd0;
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
            hi        <= {WIDTH{1'b0}};
            lo        <= {WIDTH{1'b0}};
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r     <= 5'd0;
                        acc_hi_r  <= ld_hi_s;
                        acc_lo_r  <= ld_lo_s;
                        opnd_r    <= ld_opnd_s;
                        is_div_r  <= op_e[1];
                        neg_res_r <= ld_neg_res_s;
                        neg_rem_r <= ld_neg_rem_s;
                        dz_r      <= dz_s;
                        if (!dz_s) begin
                            div_zero <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r + 5'd1;
                end
                ST_FIX: begin
                    if (!is_div_r) begin
                        if (neg_res_r) begin
                            {acc_hi_r, acc_lo_r} <= prod_neg_s;
                        end
                    end else begin
                        if (neg_res_r) begin
                            acc_lo_r <= -acc_lo_r;
                        end
                        if (neg_rem_r) begin
                            acc_hi_r <= -acc_hi_r;
                        end
                    end
                end
                ST_DONE: begin
                    hi       <= acc_hi_r;
                    lo       <= acc_lo_r;
                    done     <= 1'b1;
                    div_zero <= dz_r;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: known products/quotients, latency,
// divide-by-zero, stall behaviour while busy, mid-operation reset, flush.
module tb_muldiv_ctrl;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start_e;
    logic [1:0]  op_e;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush_e;
    logic        mfhi_d;
    logic        mflo_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        div_zero;

    int n_chk;
    int n_err;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_e   (start_e),
        .op_e      (op_e),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush_e   (flush_e),
        .mfhi_d    (mfhi_d),
        .mflo_d    (mflo_d),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency and results.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat, input logic edz);
        int lat;
        @(negedge clk);
        op_e = op; src_a = a; src_b = b; start_e = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
        chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int stall_bad;
        int hold_bad;
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; start_e = 1'b0; op_e = 2'b00; src_a = 32'd0; src_b = 32'd0;
        flush_e = 1'b0; mfhi_d = 1'b0; mflo_d = 1'b0;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst stall", {31'd0, stall_req}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst dz", {31'd0, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("mult m1*m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34, 1'b0);
        do_op("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 1'b0);
        do_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0);
        do_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b0);
        do_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 2, 1'b1);
        do_op("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 34, 1'b0);
        do_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34, 1'b0);
        do_op("mult 3*-5", OP_MULT, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 34, 1'b0);

        // Reset in the middle of a calculation.
        @(negedge clk);
        op_e = OP_MULTU; src_a = 32'h12345678; src_b = 32'd9; start_e = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("mid busy before rst", {31'd0, busy}, 32'd1);
        mfhi_d = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst stall", {31'd0, stall_req}, 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mfhi_d = 1'b0;

        // Flushed start must not be accepted.
        @(negedge clk);
        op_e = OP_MULTU; src_a = 32'd3; src_b = 32'd3; start_e = 1'b1; flush_e = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0; flush_e = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("flush busy later", {31'd0, busy}, 32'd0);

        do_op("multu 7*6", OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 34, 1'b0);

        // MFLO and a second start arrive at CALC cycle 10; flush also asserted.
        @(negedge clk);
        op_e = OP_MULTU; src_a = 32'h00010000; src_b = 32'h00010000; start_e = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0;
        lat = 0;
        repeat (10) begin
            @(posedge clk); #1;
            lat++;
        end
        mflo_d = 1'b1; start_e = 1'b1; op_e = OP_DIVU; src_a = 32'd50; src_b = 32'd5;
        flush_e = 1'b1;
        stall_bad = 0; hold_bad = 0;
        while (done !== 1'b1 && lat < 200) begin
            #1;
            if (stall_req !== 1'b1) stall_bad++;
            if (hi !== 32'd0 || lo !== 32'd42) hold_bad++;
            @(posedge clk); #1;
            lat++;
        end
        start_e = 1'b0; mflo_d = 1'b0; flush_e = 1'b0;
        chk("stall latency", 32'(lat), 32'd34);
        chk("stall held", 32'(stall_bad), 32'd0);
        chk("hilo hold", 32'(hold_bad), 32'd0);
        chk("stall hi", hi, 32'd1);
        chk("stall lo", lo, 32'd0);
        #1;
        chk("stall idle", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        chk("no 2nd accept", {31'd0, busy}, 32'd0);
        chk("done pulse", {31'd0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
